// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control unit for a small multicycle MIPS-like core.
// It sequences IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] for the
// instructions add, sub, and, or, xor, slt, addi, andi, ori, lw, sw, beq,
// bne and j. It stops in HALT after N_INSTR retired instructions, or at once
// (with err) on an undecodable instruction.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a run (only looked at in IDLE / HALT)
//   instr      : instruction word from instruction memory
//   zero       : ALU zero flag, used by beq / bne in EXEC
//   pc_clr     : clear PC (cycle that start is accepted)
//   pc_we      : PC write enable
//   pc_src     : PC source (00 pc+1, 01 branch, 10 jump)
//   ir_we      : instruction register write enable
//   reg_we     : register file write enable
//   reg_dst    : destination register select (0 rt, 1 rd)
//   mem_to_reg : write-back source (1 = memory data)
//   mem_re     : data memory read strobe
//   mem_we     : data memory write strobe
//   ext_sel    : immediate extension (0 sign, 1 zero)
//   alu_src_b  : ALU operand B (0 register, 1 immediate)
//   alu_op     : ALU operation (add 000, sub 001, and 010, or 011, xor 100, slt 101)
//   busy       : high in FETCH..WB
//   done       : high in HALT
//   err        : illegal instruction seen (held in HALT)
//   state      : current state encoding
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned N_INSTR = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_clr,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        mem_re,
    output logic        mem_we,
    output logic        ext_sel,
    output logic        alu_src_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R    = 3'd0,
        CL_IALU = 3'd1,
        CL_LW   = 3'd2,
        CL_SW   = 3'd3,
        CL_BEQ  = 3'd4,
        CL_BNE  = 3'd5,
        CL_J    = 3'd6,
        CL_ILL  = 3'd7
    } class_t;

    localparam logic [4:0] LAST_CNT = 5'(N_INSTR);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic       err_q, err_d;

    class_t     dec_class;
    logic [2:0] dec_alu_op;
    logic       dec_ext;
    logic [4:0] cnt_inc;
    logic       retire;

    // Only opcode and funct drive control; the register and immediate
    // fields go straight to the datapath.
    logic unused_instr;
    assign unused_instr = ^instr[25:6];

    // -----------------------------------------------------------------------
    // State, retire counter, latched opcode/funct and error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            funct_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Capture decode fields together with the IR so decode never
            // depends on instr changing after FETCH.
            if (ir_we) begin
                op_q    <= instr[31:26];
                funct_q <= instr[5:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Instruction decode from the latched fields
    // -----------------------------------------------------------------------
    always_comb begin
        dec_class  = CL_ILL;
        dec_alu_op = 3'b000;
        dec_ext    = 1'b0;
        case (op_q)
            6'b000000: begin
                case (funct_q)
                    6'b100000: begin dec_class = CL_R; dec_alu_op = 3'b000; end
                    6'b100010: begin dec_class = CL_R; dec_alu_op = 3'b001; end
                    6'b100100: begin dec_class = CL_R; dec_alu_op = 3'b010; end
                    6'b100101: begin dec_class = CL_R; dec_alu_op = 3'b011; end
                    6'b100110: begin dec_class = CL_R; dec_alu_op = 3'b100; end
                    6'b101010: begin dec_class = CL_R; dec_alu_op = 3'b101; end
                    default:   dec_class = CL_ILL;
                endcase
            end
            6'b001000: begin dec_class = CL_IALU; dec_alu_op = 3'b000; end
            6'b001100: begin dec_class = CL_IALU; dec_alu_op = 3'b010; dec_ext = 1'b1; end
            6'b001101: begin dec_class = CL_IALU; dec_alu_op = 3'b011; dec_ext = 1'b1; end
            6'b100011: begin dec_class = CL_LW;   dec_alu_op = 3'b000; end
            6'b101011: begin dec_class = CL_SW;   dec_alu_op = 3'b000; end
            6'b000100: begin dec_class = CL_BEQ;  dec_alu_op = 3'b001; end
            6'b000101: begin dec_class = CL_BNE;  dec_alu_op = 3'b001; end
            6'b000010: begin dec_class = CL_J;    dec_alu_op = 3'b000; end
            default:   dec_class = CL_ILL;
        endcase
    end

    assign cnt_inc = cnt_q + 5'd1;

    // -----------------------------------------------------------------------
    // Next state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        retire     = 1'b0;
        pc_clr     = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        ext_sel    = 1'b0;
        alu_src_b  = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 3'b000;

        case (state_q)
            S_IDLE, S_HALT: begin
                // rst_n gating keeps pc_clr low while reset is held even
                // if start is already high.
                if (start && rst_n) begin
                    pc_clr  = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_class == CL_ILL) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op    = dec_alu_op;
                ext_sel   = dec_ext;
                alu_src_b = (dec_class == CL_IALU) || (dec_class == CL_LW) ||
                            (dec_class == CL_SW);
                case (dec_class)
                    CL_R, CL_IALU: state_d = S_WB;
                    CL_LW, CL_SW:  state_d = S_MEM;
                    CL_BEQ: begin
                        retire = 1'b1;
                        if (zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'b01;
                        end
                    end
                    CL_BNE: begin
                        retire = 1'b1;
                        if (!zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'b01;
                        end
                    end
                    CL_J: begin
                        retire = 1'b1;
                        pc_we  = 1'b1;
                        pc_src = 2'b10;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (dec_class == CL_LW) begin
                    mem_re  = 1'b1;
                    state_d = S_WB;
                end else begin
                    mem_we = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (dec_class == CL_R);
                mem_to_reg = (dec_class == CL_LW);
                retire     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Every retire cycle shares the same exit: next FETCH, or HALT once
        // the run length is reached.
        if (retire) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == LAST_CNT) ? S_HALT : S_FETCH;
        end
    end

    assign state = state_q;
    assign busy  = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_MEM)    ||
                   (state_q == S_WB);
    assign done  = (state_q == S_HALT);
    assign err   = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Table of instructions with their hand-written expected control values,
// expanded into per-cycle expected records queued when an instruction is
// presented and compared cycle by cycle. Hand sequences cover illegal
// instructions, the full 28-instruction run and reset in mid-instruction.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] instr;
    logic        zero;
    logic        pc_clr, pc_we, ir_we, reg_we, reg_dst, mem_to_reg;
    logic        mem_re, mem_we, ext_sel, alu_src_b, busy, done, err;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [2:0]  state;

    multicycle_ctrl #(.N_INSTR(28)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .instr      (instr),
        .zero       (zero),
        .pc_clr     (pc_clr),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .ext_sel    (ext_sel),
        .alu_src_b  (alu_src_b),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    // {state, pc_clr, pc_we, ir_we, reg_we, reg_dst, mem_to_reg, mem_re,
    //  mem_we, ext_sel, alu_src_b, busy, done, err, pc_src, alu_op}
    logic [20:0] obs;
    assign obs = {state, pc_clr, pc_we, ir_we, reg_we, reg_dst, mem_to_reg,
                  mem_re, mem_we, ext_sel, alu_src_b, busy, done, err,
                  pc_src, alu_op};

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        int          ncyc;     // FETCH to retire, inclusive
        logic        is_mem;
        logic        mem_rd;
        logic [2:0]  alu_op;   // in EXEC
        logic        src_b;    // in EXEC
        logic        ext;      // in EXEC
        logic        pc_we;    // in EXEC
        logic [1:0]  pc_src;   // in EXEC
        logic        dst;      // in WB
        logic        m2r;      // in WB
    } vec_t;

    vec_t        tbl[17];
    logic [20:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [20:0] pk(logic [2:0] st, logic pcclr, logic pcwe,
                                       logic irwe, logic regwe, logic rdst,
                                       logic m2r, logic mre, logic mwe,
                                       logic ext, logic srcb, logic bsy,
                                       logic dn, logic er, logic [1:0] pcsrc,
                                       logic [2:0] aop);
        return {st, pcclr, pcwe, irwe, regwe, rdst, m2r, mre, mwe, ext, srcb,
                bsy, dn, er, pcsrc, aop};
    endfunction

    function automatic vec_t mkv(string nm, logic [5:0] op, logic [5:0] low,
                                 logic z, int n, logic ism, logic mrd,
                                 logic [2:0] aop, logic sb, logic ex,
                                 logic pw, logic [1:0] ps, logic d, logic m);
        vec_t v;
        v.name   = nm;
        v.instr  = {op, 20'hA5C3E, low};
        v.zero   = z;
        v.ncyc   = n;
        v.is_mem = ism;
        v.mem_rd = mrd;
        v.alu_op = aop;
        v.src_b  = sb;
        v.ext    = ex;
        v.pc_we  = pw;
        v.pc_src = ps;
        v.dst    = d;
        v.m2r    = m;
        return v;
    endfunction

    function automatic logic [20:0] halt_exp(logic e);
        return pk(3'd6, 0,0,0,0,0,0,0,0,0,0, 1'b0, 1'b1, e, 2'b00, 3'b000);
    endfunction

    function automatic logic [20:0] idle_exp();
        return pk(3'd0, 0,0,0,0,0,0,0,0,0,0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
    endfunction

    task automatic chk(string nm, logic [20:0] got, logic [20:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                      nm, got[20:18], got[17:0], expv[20:18], expv[17:0]);
    endtask

    task automatic chk_bit(string nm, logic got, logic expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, got, expv);
    endtask

    // Push the FETCH/DECODE prefix that every instruction shares.
    task automatic push_prefix();
        exp_q.push_back(pk(3'd1, 0,1,1,0,0,0,0,0,0,0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
        exp_q.push_back(pk(3'd2, 0,0,0,0,0,0,0,0,0,0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
    endtask

    // Drain the queue one record per cycle; on return the bench sits just
    // after the edge that leaves the last compared state.
    task automatic drain(string nm);
        int n;
        logic [20:0] e;
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("%s cyc%0d", nm, c), obs, e);
            @(posedge clk);
            #1;
        end
    endtask

    // Called in the FETCH cycle.
    task automatic run_instr(vec_t v);
        instr = v.instr;
        zero  = v.zero;
        push_prefix();
        exp_q.push_back(pk(3'd3, 1'b0, v.pc_we, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, v.ext, v.src_b, 1'b1, 1'b0, 1'b0, v.pc_src,
                           v.alu_op));
        if (v.is_mem)
            exp_q.push_back(pk(3'd4, 0,0,0,0,0,0, v.mem_rd, !v.mem_rd, 0,0,
                               1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
        if (v.ncyc == 5 || (v.ncyc == 4 && !v.is_mem))
            exp_q.push_back(pk(3'd5, 0,0,0,1'b1, v.dst, v.m2r, 0,0,0,0,
                               1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
        drain(v.name);
        $display("instr %-10s zero=%b retired after %0d cycles", v.name, v.zero, v.ncyc);
    endtask

    // Called in IDLE/HALT; returns in the FETCH cycle.
    task automatic do_start(string nm);
        @(negedge clk);
        start = 1'b1;
        #1;
        chk_bit({nm, " pc_clr"}, pc_clr, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_illegal(string nm, logic [31:0] w);
        instr = w;
        zero  = 1'b0;
        push_prefix();
        drain(nm);
        @(negedge clk);
        chk({nm, " halt"}, obs, halt_exp(1'b1));
        @(negedge clk);
        chk({nm, " halt hold"}, obs, halt_exp(1'b1));
        $display("instr %-10s illegal, halted with err", nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t addi_v;
        vec_t sw_v;
        //         name        op     low    z  n  mem rd  aluop  sb ex pw pcsrc dst m2r
        tbl[0]  = mkv("add",     6'h00, 6'h20, 0, 4, 0, 0, 3'b000, 0, 0, 0, 2'b00, 1, 0);
        tbl[1]  = mkv("sub",     6'h00, 6'h22, 0, 4, 0, 0, 3'b001, 0, 0, 0, 2'b00, 1, 0);
        tbl[2]  = mkv("and",     6'h00, 6'h24, 0, 4, 0, 0, 3'b010, 0, 0, 0, 2'b00, 1, 0);
        tbl[3]  = mkv("or",      6'h00, 6'h25, 0, 4, 0, 0, 3'b011, 0, 0, 0, 2'b00, 1, 0);
        tbl[4]  = mkv("xor",     6'h00, 6'h26, 0, 4, 0, 0, 3'b100, 0, 0, 0, 2'b00, 1, 0);
        tbl[5]  = mkv("slt",     6'h00, 6'h2A, 0, 4, 0, 0, 3'b101, 0, 0, 0, 2'b00, 1, 0);
        tbl[6]  = mkv("addi",    6'h08, 6'h2A, 0, 4, 0, 0, 3'b000, 1, 0, 0, 2'b00, 0, 0);
        tbl[7]  = mkv("andi",    6'h0C, 6'h22, 0, 4, 0, 0, 3'b010, 1, 1, 0, 2'b00, 0, 0);
        tbl[8]  = mkv("ori",     6'h0D, 6'h3F, 0, 4, 0, 0, 3'b011, 1, 1, 0, 2'b00, 0, 0);
        tbl[9]  = mkv("lw",      6'h23, 6'h04, 0, 5, 1, 1, 3'b000, 1, 0, 0, 2'b00, 0, 1);
        tbl[10] = mkv("sw",      6'h2B, 6'h08, 0, 4, 1, 0, 3'b000, 1, 0, 0, 2'b00, 0, 0);
        tbl[11] = mkv("beq_z1",  6'h04, 6'h10, 1, 3, 0, 0, 3'b001, 0, 0, 1, 2'b01, 0, 0);
        tbl[12] = mkv("beq_z0",  6'h04, 6'h10, 0, 3, 0, 0, 3'b001, 0, 0, 0, 2'b00, 0, 0);
        tbl[13] = mkv("bne_z1",  6'h05, 6'h10, 1, 3, 0, 0, 3'b001, 0, 0, 0, 2'b00, 0, 0);
        tbl[14] = mkv("bne_z0",  6'h05, 6'h10, 0, 3, 0, 0, 3'b001, 0, 0, 1, 2'b01, 0, 0);
        tbl[15] = mkv("j",       6'h02, 6'h20, 1, 3, 0, 0, 3'b000, 0, 0, 1, 2'b10, 0, 0);
        tbl[16] = mkv("addi2",   6'h08, 6'h01, 1, 4, 0, 0, 3'b000, 1, 0, 0, 2'b00, 0, 0);

        rst_n = 1'b0;
        start = 1'b0;
        instr = 32'h0;
        zero  = 1'b0;

        // Reset state and waiting in IDLE without start.
        #12;
        chk("reset state", obs, idle_exp());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle wait %0d", i), obs, idle_exp());
        end

        // Every legal instruction once, back to back in one run.
        do_start("start1");
        for (int i = 0; i < 17; i++) run_instr(tbl[i]);

        // Illegal opcode, then restart from HALT clears err.
        run_illegal("ill_op", 32'hFC00_0020);
        do_start("restart_op");
        // Illegal funct under op 000000.
        run_illegal("ill_funct", 32'h0000_0021);
        do_start("restart_funct");

        // 28 addi: done exactly after the 28th WB; start held high during
        // part of the run must not restart it.
        addi_v = tbl[6];
        for (int i = 0; i < 28; i++) begin
            if (i == 2)  start = 1'b1;
            if (i == 10) start = 1'b0;
            addi_v.name = $sformatf("addi#%0d", i + 1);
            run_instr(addi_v);
        end
        @(negedge clk);
        chk("run28 done", obs, halt_exp(1'b0));

        // Reset in the EXEC cycle of sw.
        do_start("start_sw");
        sw_v  = tbl[10];
        instr = sw_v.instr;
        zero  = 1'b0;
        push_prefix();
        exp_q.push_back(pk(3'd3, 0,0,0,0,0,0,0,0,0,1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
        drain("sw_exec");
        // drain left us in MEM; step back to check the EXEC-time reset on a
        // fresh sw instead.
        @(negedge clk);
        chk("sw mem", obs, pk(3'd4, 0,0,0,0,0,0,0,1'b1,0,0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
        @(posedge clk);
        #1;
        instr = sw_v.instr;
        push_prefix();
        drain("sw2");
        @(negedge clk);
        chk("sw2 exec", obs, pk(3'd3, 0,0,0,0,0,0,0,0,0,1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset in exec", obs, idle_exp());
        chk_bit("async reset mem_we", mem_we, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post reset idle %0d", i), obs, idle_exp());
        end

        // Recovery after reset.
        do_start("start_after_reset");
        run_instr(tbl[0]);
        run_instr(tbl[9]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
